collision_scanner: RTL

Parametrised multi-projectile, multi-object collision detector for the game core. On each `clk_collision` tick it snapshots up to N_PROJ projectile points and N_OBJ object boxes, scans every pair sequentially with one pair per cycle, and reports each hit through a valid/ready event port. It also publishes per-scan hit masks. It replaces single-pair detection between the projectile movers and the alien-grid and score logic.

---
 rtl/collision_scanner_if.sv | 13 +
 rtl/collision_scanner.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/collision_scanner_if.sv
// Hit-event valid/ready channel between collision_scanner (master) and its consumer (slave).
interface collision_scanner_if #(
    parameter int PIDX_W = 2,
    parameter int OIDX_W = 3
);
    logic              hit_valid;
    logic              hit_ready;
    logic [PIDX_W-1:0] hit_proj;
    logic [OIDX_W-1:0] hit_obj;

    modport master (output hit_valid, hit_proj, hit_obj, input hit_ready);
    modport slave  (input hit_valid, hit_proj, hit_obj, output hit_ready);
endinterface

// File: rtl/collision_scanner.sv
// Sequential projectile/object collision scanner, one pair per cycle, hits reported over a valid/ready channel.
// Define COLLISION_OVERLAP_EN for sized projectiles (rectangle overlap); default is point-in-box.
module collision_scanner #(
    parameter int N_PROJ  = 4,
    parameter int N_OBJ   = 8,
    parameter int COORD_W = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_collision,
    input  logic [N_PROJ*COORD_W-1:0] proj_x,
    input  logic [N_PROJ*COORD_W-1:0] proj_y,
    input  logic [N_PROJ-1:0]         proj_valid,
    input  logic [N_OBJ*COORD_W-1:0]  obj_x,
    input  logic [N_OBJ*COORD_W-1:0]  obj_y,
    input  logic [N_OBJ-1:0]          obj_alive,
    input  logic [COORD_W-1:0]        obj_width,
    input  logic [COORD_W-1:0]        obj_height,
`ifdef COLLISION_OVERLAP_EN
    input  logic [COORD_W-1:0]        proj_width,
    input  logic [COORD_W-1:0]        proj_height,
`endif
    collision_scanner_if.master       hit_if,
    output logic                      busy,
    output logic                      done,
    output logic [N_PROJ-1:0]         proj_hit,
    output logic [N_OBJ-1:0]          obj_hit,
    output logic                      overrun
);
    localparam int PIDX_W = (N_PROJ > 1) ? $clog2(N_PROJ) : 1;
    localparam int OIDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
    localparam int EXT_W  = COORD_W + 1;
    localparam logic [PIDX_W-1:0] P_LAST = PIDX_W'(N_PROJ - 1);
    localparam logic [OIDX_W-1:0] O_LAST = OIDX_W'(N_OBJ - 1);

    typedef enum logic [1:0] {IDLE, SCAN, HOLD, DONE} state_t;

    state_t              state_q, state_d;
    logic [PIDX_W-1:0]   p_q, p_d;
    logic [OIDX_W-1:0]   o_q, o_d;
    logic [N_PROJ-1:0]   work_proj_q, work_proj_d;
    logic [N_OBJ-1:0]    work_obj_q, work_obj_d;
    logic                hit_valid_q, hit_valid_d;
    logic [PIDX_W-1:0]   hit_proj_q, hit_proj_d;
    logic [OIDX_W-1:0]   hit_obj_q, hit_obj_d;
    logic [N_PROJ-1:0]   proj_hit_q, proj_hit_d;
    logic [N_OBJ-1:0]    obj_hit_q, obj_hit_d;
    logic                overrun_q, overrun_d;
    logic                snap_en;

    logic [COORD_W-1:0]  snap_px_q [N_PROJ];
    logic [COORD_W-1:0]  snap_py_q [N_PROJ];
    logic [COORD_W-1:0]  snap_ox_q [N_OBJ];
    logic [COORD_W-1:0]  snap_oy_q [N_OBJ];
    logic [N_PROJ-1:0]   snap_pv_q;
    logic [N_OBJ-1:0]    snap_alive_q;
    logic [COORD_W-1:0]  snap_w_q, snap_h_q;
`ifdef COLLISION_OVERLAP_EN
    logic [COORD_W-1:0]  snap_pw_q, snap_ph_q;
`endif

    // NOTE: the snapshot is pure data, always loaded before it is read, so it carries no reset.
    always_ff @(posedge clk) begin
        if (snap_en) begin
            for (int i = 0; i < N_PROJ; i++) begin
                snap_px_q[i] <= proj_x[i*COORD_W +: COORD_W];
                snap_py_q[i] <= proj_y[i*COORD_W +: COORD_W];
            end
            for (int j = 0; j < N_OBJ; j++) begin
                snap_ox_q[j] <= obj_x[j*COORD_W +: COORD_W];
                snap_oy_q[j] <= obj_y[j*COORD_W +: COORD_W];
            end
            snap_pv_q    <= proj_valid;
            snap_alive_q <= obj_alive;
            snap_w_q     <= obj_width;
            snap_h_q     <= obj_height;
`ifdef COLLISION_OVERLAP_EN
            snap_pw_q    <= proj_width;
            snap_ph_q    <= proj_height;
`endif
        end
    end

    logic [COORD_W-1:0] px, py, ox, oy;
    logic [EXT_W-1:0]   ox_end, oy_end;
`ifdef COLLISION_OVERLAP_EN
    logic [EXT_W-1:0]   px_end, py_end;
`endif
    logic               geo_hit, pair_hit;

    // Ends are formed one bit wider so boxes touching the top of the coordinate range never wrap.
    always_comb begin
        px     = snap_px_q[p_q];
        py     = snap_py_q[p_q];
        ox     = snap_ox_q[o_q];
        oy     = snap_oy_q[o_q];
        ox_end = EXT_W'(ox) + EXT_W'(snap_w_q);
        oy_end = EXT_W'(oy) + EXT_W'(snap_h_q);
`ifdef COLLISION_OVERLAP_EN
        px_end  = EXT_W'(px) + EXT_W'(snap_pw_q);
        py_end  = EXT_W'(py) + EXT_W'(snap_ph_q);
        geo_hit = (snap_w_q != '0) && (snap_h_q != '0) &&
                  (snap_pw_q != '0) && (snap_ph_q != '0) &&
                  (EXT_W'(px) < ox_end) && (EXT_W'(ox) < px_end) &&
                  (EXT_W'(py) < oy_end) && (EXT_W'(oy) < py_end);
`else
        geo_hit = (snap_w_q != '0) && (snap_h_q != '0) &&
                  (px >= ox) && (EXT_W'(px) < ox_end) &&
                  (py >= oy) && (EXT_W'(py) < oy_end);
`endif
        pair_hit = snap_pv_q[p_q] && snap_alive_q[o_q] && !work_obj_q[o_q] && geo_hit;
    end

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        o_d         = o_q;
        work_proj_d = work_proj_q;
        work_obj_d  = work_obj_q;
        hit_valid_d = hit_valid_q;
        hit_proj_d  = hit_proj_q;
        hit_obj_d   = hit_obj_q;
        proj_hit_d  = proj_hit_q;
        obj_hit_d   = obj_hit_q;
        snap_en     = 1'b0;
        overrun_d   = clk_collision && (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (clk_collision) begin
                    snap_en     = 1'b1;
                    work_proj_d = '0;
                    work_obj_d  = '0;
                    p_d         = '0;
                    o_d         = '0;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                if (pair_hit) begin
                    hit_valid_d      = 1'b1;
                    hit_proj_d       = p_q;
                    hit_obj_d        = o_q;
                    work_proj_d[p_q] = 1'b1;
                    work_obj_d[o_q]  = 1'b1;
                    state_d          = HOLD;
                end else if (o_q != O_LAST) begin
                    o_d = o_q + 1'b1;
                end else if (p_q != P_LAST) begin
                    p_d = p_q + 1'b1;
                    o_d = '0;
                end else begin
                    proj_hit_d = work_proj_q;
                    obj_hit_d  = work_obj_q;
                    state_d    = DONE;
                end
            end
            HOLD: begin
                // The remaining objects of this projectile are skipped after acceptance.
                if (hit_if.hit_ready) begin
                    hit_valid_d = 1'b0;
                    if (p_q != P_LAST) begin
                        p_d     = p_q + 1'b1;
                        o_d     = '0;
                        state_d = SCAN;
                    end else begin
                        proj_hit_d = work_proj_q;
                        obj_hit_d  = work_obj_q;
                        state_d    = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            p_q         <= '0;
            o_q         <= '0;
            work_proj_q <= '0;
            work_obj_q  <= '0;
            hit_valid_q <= 1'b0;
            hit_proj_q  <= '0;
            hit_obj_q   <= '0;
            proj_hit_q  <= '0;
            obj_hit_q   <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            o_q         <= o_d;
            work_proj_q <= work_proj_d;
            work_obj_q  <= work_obj_d;
            hit_valid_q <= hit_valid_d;
            hit_proj_q  <= hit_proj_d;
            hit_obj_q   <= hit_obj_d;
            proj_hit_q  <= proj_hit_d;
            obj_hit_q   <= obj_hit_d;
            overrun_q   <= overrun_d;
        end
    end

    assign hit_if.hit_valid = hit_valid_q;
    assign hit_if.hit_proj  = hit_proj_q;
    assign hit_if.hit_obj   = hit_obj_q;
    assign busy             = (state_q != IDLE);
    assign done             = (state_q == DONE);
    assign proj_hit         = proj_hit_q;
    assign obj_hit          = obj_hit_q;
    assign overrun          = overrun_q;
endmodule
